csc_matrix_stream: RTL
======================

// Module: csc_matrix_stream
// PURPOSE
//   Streaming 3x3 colour-space converter with loadable coefficients and per-channel offsets.
//   Successor to the fixed RGB->YCbCr stage: generalised pixel and output widths, plus rounding,
//   optional saturation, and a shadow coefficient bank that swaps only at frame boundaries.
//   Sits after the filter stage; consumes RGB pixel stream, emits 3 signed fixed-point channels.
// PARAMETERS
//   width      320    pixels per line
//   height     240    lines per frame
//   frameSize  width*height  pixels per frame (oDone period)
//   DATA_W     8      bits per input channel (unsigned)
//   COEF_W     18     signed coefficient width
//   COEF_FRAC  17     coefficient fraction bits
//   OUT_W      18     signed output width
//   OUT_FRAC   9      output fraction bits (must be < COEF_FRAC)
// PORTS
//   clk         in   1          clock
//   reset       in   1          synchronous, active-high
//   iValid      in   1          pixel valid; no backpressure
//   iData       in   3*DATA_W   {R,G,B}, R in MSBs
//   iCoefWe     in   1          shadow-bank write strobe
//   iCoefAddr   in   4          0..8 coef row-major (A0,A1,A2,B0..C2); 9..11 offset A,B,C; 12..15 ignored
//   iCoefData   in   COEF_W     write data (signed)
//   iCoefCommit in   1          request shadow->active swap at next frame boundary
//   oY,oCb,oCr  out  OUT_W      signed results (rows A,B,C), OUT_FRAC fraction bits
//   oValid      out  1          result valid
//   oDone       out  1          1-cycle pulse with last pixel of each frame
//   oPending    out  1          commit requested, swap not yet done
// BEHAVIOUR
//   Reset: oValid/oDone/oPending=0, outputs 0, counters 0, pipeline flushed; active and shadow
//     banks = BT.601 defaults {39164,76926,14982,-22138,-43398,65536,65536,-54906,-10630}, offsets 0.
//   Latency fixed 3 cycles: iValid at cycle N -> oValid at N+3; gaps preserved; full throughput.
//   S1: register 9 products signed({1'b0,ch})*coef plus snapshot of active offsets.
//   S2: acc = p0+p1+p2 + (offset <<< (COEF_FRAC-OUT_FRAC)); acc width DATA_W+COEF_W+3, no overflow.
//   S3: r = (acc + 2^(COEF_FRAC-OUT_FRAC-1)) >>> (COEF_FRAC-OUT_FRAC) (arith; round half up),
//     then reduce to OUT_W (see CONFIGURATION).
//   Offsets are signed with OUT_FRAC fraction bits.
//   Frame counting: inCnt counts accepted input pixels, outCnt counts oValid beats; both wrap
//     at frameSize-1 -> 0. oDone=1 on the same cycle as oValid of beat frameSize-1.
//   Coef write: iCoefWe writes shadow[iCoefAddr] next edge; never touches active bank directly.
//   Commit: iCoefCommit sets pending (stays set if already pending). Swap (active<=shadow,
//     pending<=0) occurs when pending and either (a) last pixel of frame accepted this cycle
//     (swap effective next cycle), or (b) inCnt==0 and iValid==0 (idle).
//     Pixels keep the bank latched at S1: no frame ever mixes banks.
//   Simultaneous: write+commit same cycle -> write included in swap; commit on swap cycle ->
//     pending stays 1 for following boundary; write on swap cycle lands in shadow only.
//   Reset mid-frame: in-flight pixels dropped, no oDone, pending cleared, banks to defaults.
// CONFIGURATION
//   CSC_CLAMP_EN defined: r saturated to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
//   CSC_CLAMP_EN undefined: r truncated to low OUT_W bits (two's-complement wrap).
// TESTING (defaults unless stated; values are oY/oCb/oCr)
//   Reset; RGB(255,255,255) -> 3 cycles later 130560 / 0 / 0, oValid 1 cycle.
//   RGB(255,0,0) -> 39011 / -22052 / 65280 (checks rounding of negatives).
//   width=4,height=2; 8 pixels with random gaps -> oDone with 8th oValid only; 2nd frame same.
//   Mid-frame load all coefs 131071, offsets 0, commit -> oPending=1; rest of frame uses
//     defaults; first pixel of next frame (255,255,255) -> 131071 each with CSC_CLAMP_EN,
//     129533 each without.
//   Idle load offset A=512, commit with inCnt==0 -> oPending drops next cycle;
//     RGB(0,0,0) -> 512 / 0 / 0.
//   3 pixels then reset 1 cycle -> oValid 0 thereafter; next oDone after full frameSize pixels.

Source files
------------

// File: rtl/csc_matrix_stream.sv
// Streaming 3x3 colour-space converter: {R,G,B} unsigned pixels -> three signed fixed-point
// channels, fixed 3-cycle latency, full throughput. Coefficients and offsets are written into a
// shadow bank and swapped into the active bank only at frame boundaries or while idle.
// Optional feature macro: CSC_CLAMP_EN (saturate results instead of two's-complement wrap).
module csc_matrix_stream #(
  parameter int unsigned width     = 320,
  parameter int unsigned height    = 240,
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned COEF_W    = 18,
  parameter int unsigned COEF_FRAC = 17,
  parameter int unsigned OUT_W     = 18,
  parameter int unsigned OUT_FRAC  = 9
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  iValid,
  input  logic [3*DATA_W-1:0]   iData,
  input  logic                  iCoefWe,
  input  logic [3:0]            iCoefAddr,
  input  logic [COEF_W-1:0]     iCoefData,
  input  logic                  iCoefCommit,
  output logic [OUT_W-1:0]      oY,
  output logic [OUT_W-1:0]      oCb,
  output logic [OUT_W-1:0]      oCr,
  output logic                  oValid,
  output logic                  oDone,
  output logic                  oPending
);

  localparam int unsigned frameSize = width * height;
  localparam int unsigned CntW      = (frameSize > 1) ? $clog2(frameSize) : 1;
  localparam int unsigned ProdW     = DATA_W + 1 + COEF_W;
  localparam int unsigned AccW      = DATA_W + COEF_W + 3;
  localparam int unsigned Shift     = COEF_FRAC - OUT_FRAC;

  localparam logic [CntW-1:0]        LastCnt = CntW'(frameSize - 1);
  localparam logic signed [AccW-1:0] RoundK  = AccW'(2 ** (Shift - 1));
`ifdef CSC_CLAMP_EN
  localparam logic signed [AccW-1:0] OutMax  = AccW'(2 ** (OUT_W - 1) - 1);
  localparam logic signed [AccW-1:0] OutMin  = AccW'(-(2 ** (OUT_W - 1)));
`endif

  typedef logic signed [COEF_W-1:0] coef_t;

  // Entries 0..8 are the row-major matrix (BT.601), 9..11 the per-row offsets.
  localparam coef_t DefBank [12] = '{
    coef_t'(39164),  coef_t'(76926),  coef_t'(14982),
    coef_t'(-22138), coef_t'(-43398), coef_t'(65536),
    coef_t'(65536),  coef_t'(-54906), coef_t'(-10630),
    coef_t'(0),      coef_t'(0),      coef_t'(0)
  };

  // Bank control and frame-position state
  coef_t           shadow_q [12];
  coef_t           shadow_d [12];
  coef_t           active_q [12];
  coef_t           active_d [12];
  logic            pending_q, pending_d;
  logic [CntW-1:0] in_cnt_q, in_cnt_d;
  logic            last_in, swap;

  // Pipeline state
  logic                    v1_q, v1_d, v2_q, v2_d;
  logic signed [ProdW-1:0] prod_q [9];
  logic signed [ProdW-1:0] prod_d [9];
  coef_t                   off1_q [3];
  coef_t                   off1_d [3];
  logic signed [AccW-1:0]  acc_q [3];
  logic signed [AccW-1:0]  acc_d [3];
  logic [OUT_W-1:0]        out_q [3];
  logic [OUT_W-1:0]        out_d [3];
  logic                    valid_q, valid_d, done_q, done_d;
  logic [CntW-1:0]         out_cnt_q, out_cnt_d;

  logic [DATA_W-1:0]       ch [3];
  logic signed [AccW-1:0]  rnd [3];
  logic                    unused_rnd_hi;

  // Shadow writes, commit tracking, and the shadow->active swap at frame boundaries.
  always_comb begin
    shadow_d  = shadow_q;
    active_d  = active_q;
    pending_d = pending_q;
    in_cnt_d  = in_cnt_q;
    last_in   = iValid && (in_cnt_q == LastCnt);
    if (iValid) begin
      in_cnt_d = last_in ? '0 : in_cnt_q + 1'b1;
    end
    // The pixel accepted this cycle still uses the old bank; the new one applies from next cycle.
    swap = pending_q && (last_in || ((in_cnt_q == '0) && !iValid));
    if (swap) begin
      active_d  = shadow_q;
      pending_d = 1'b0;
    end
    // A commit arriving on the swap cycle re-arms for the following boundary.
    if (iCoefCommit) begin
      pending_d = 1'b1;
    end
    if (iCoefWe && (iCoefAddr < 4'd12)) begin
      shadow_d[iCoefAddr] = iCoefData;
    end
  end

  // S1: nine products against the active bank, plus a snapshot of the active offsets.
  always_comb begin
    ch[0] = iData[3*DATA_W-1 -: DATA_W];
    ch[1] = iData[2*DATA_W-1 -: DATA_W];
    ch[2] = iData[DATA_W-1:0];
    v1_d  = iValid;
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        prod_d[3*i+j] = ProdW'($signed({1'b0, ch[j]})) * ProdW'(active_q[3*i+j]);
      end
      off1_d[i] = active_q[9+i];
    end
  end

  // S2: row sums with the offset aligned to the coefficient fraction.
  always_comb begin
    v2_d = v1_q;
    for (int i = 0; i < 3; i++) begin
      acc_d[i] = AccW'(prod_q[3*i]) + AccW'(prod_q[3*i+1]) + AccW'(prod_q[3*i+2])
               + (AccW'(off1_q[i]) <<< Shift);
    end
  end

  // S3: round half up, reduce to the output width, and count output beats for oDone.
  always_comb begin
    valid_d   = v2_q;
    done_d    = v2_q && (out_cnt_q == LastCnt);
    out_cnt_d = out_cnt_q;
    if (v2_q) begin
      out_cnt_d = done_d ? '0 : out_cnt_q + 1'b1;
    end
    for (int i = 0; i < 3; i++) begin
      rnd[i]   = (acc_q[i] + RoundK) >>> Shift;
      out_d[i] = out_q[i];
      if (v2_q) begin
`ifdef CSC_CLAMP_EN
        if (rnd[i] > OutMax) begin
          out_d[i] = OutMax[OUT_W-1:0];
        end else if (rnd[i] < OutMin) begin
          out_d[i] = OutMin[OUT_W-1:0];
        end else begin
          out_d[i] = rnd[i][OUT_W-1:0];
        end
`else
        out_d[i] = rnd[i][OUT_W-1:0];
`endif
      end
    end
  end

  // High bits of the rounded value are dropped when results wrap.
  assign unused_rnd_hi = ^{rnd[0][AccW-1:OUT_W], rnd[1][AccW-1:OUT_W], rnd[2][AccW-1:OUT_W]};

  // All state, with synchronous reset to defaults and an empty pipeline.
  always_ff @(posedge clk) begin
    if (reset) begin
      shadow_q  <= DefBank;
      active_q  <= DefBank;
      pending_q <= 1'b0;
      in_cnt_q  <= '0;
      v1_q      <= 1'b0;
      v2_q      <= 1'b0;
      valid_q   <= 1'b0;
      done_q    <= 1'b0;
      out_cnt_q <= '0;
      for (int k = 0; k < 9; k++) begin
        prod_q[k] <= '0;
      end
      for (int k = 0; k < 3; k++) begin
        off1_q[k] <= '0;
        acc_q[k]  <= '0;
        out_q[k]  <= '0;
      end
    end else begin
      shadow_q  <= shadow_d;
      active_q  <= active_d;
      pending_q <= pending_d;
      in_cnt_q  <= in_cnt_d;
      v1_q      <= v1_d;
      v2_q      <= v2_d;
      valid_q   <= valid_d;
      done_q    <= done_d;
      out_cnt_q <= out_cnt_d;
      prod_q    <= prod_d;
      off1_q    <= off1_d;
      acc_q     <= acc_d;
      out_q     <= out_d;
    end
  end

  assign oY       = out_q[0];
  assign oCb      = out_q[1];
  assign oCr      = out_q[2];
  assign oValid   = valid_q;
  assign oDone    = done_q;
  assign oPending = pending_q;

endmodule
